// File: rtl/motor_pwm_ramp.sv
// Soft-start H-bridge driver: 1 kHz / 1 % PWM from a 100 kHz tick, ramped duty, zero-crossing reversal, short-brake.
// Latency: pins are registered one sysclk after the tick or state change that causes them; brake reaches the pins in 2 cycles.
// Backpressure: none; the block free-runs and samples its request inputs every cycle.
module motor_pwm_ramp #(
  parameter int PERIOD_TICKS = 100,
  parameter int RAMP_DIV     = 10
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       i_100khz_clk,
  input  logic [6:0] i_duty_target,
  input  logic       i_run,
  input  logic       i_dir,
  input  logic       i_brake,
  output logic       o_pwm,
  output logic       o_in1,
  output logic       o_in2,
  output logic [6:0] o_duty_now,
  output logic       o_busy,
  output logic [1:0] o_state
);

  localparam int PWM_W  = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [PWM_W-1:0]  PWM_LAST  = PWM_W'(PERIOD_TICKS - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [6:0]        DUTY_FULL = 7'(PERIOD_TICKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    RUN   = 2'd2,
    BRAKE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  logic              clk_q;
  logic              tick;

  logic [PWM_W-1:0]  pwm_cnt;
  logic              pwm_wrap;
  logic [6:0]        duty_shadow;

  logic [6:0]        duty_q;
  logic [6:0]        duty_next;
  logic [RAMP_W-1:0] ramp_cnt;
  logic [RAMP_W-1:0] ramp_next;
  logic              ramp_wrap;
  logic              dir_q;
  logic              dir_next;
  // Dead interval after a reversal: both bridge inputs low for one step.
  logic              dead_q;
  logic              dead_next;

  logic [6:0]        tgt_clamp;
  logic [6:0]        tgt;
  logic              drive;

  // Edge-detect the prescaler square wave; it is only ever sampled as data.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      clk_q <= 1'b0;
    end else begin
      clk_q <= i_100khz_clk;
    end
  end

  assign tick      = i_100khz_clk & ~clk_q;
  assign pwm_wrap  = tick && (pwm_cnt == PWM_LAST);
  assign ramp_wrap = tick && (ramp_cnt == RAMP_LAST);

  // PWM period counter; the duty shadow only reloads at the wrap so a period is never cut short.
  always_ff @(posedge sysclk) begin
    if (reset || i_brake || (state == BRAKE)) begin
      pwm_cnt     <= '0;
      duty_shadow <= '0;
    end else if (tick) begin
      if (pwm_wrap) begin
        pwm_cnt     <= '0;
        duty_shadow <= duty_q;
      end else begin
        pwm_cnt     <= pwm_cnt + PWM_W'(1);
      end
    end
  end

  // Effective target: clamped request, forced to zero on run drop or while a reversal is pending.
  always_comb begin
    tgt_clamp = (i_duty_target > DUTY_FULL) ? DUTY_FULL : i_duty_target;
    tgt       = tgt_clamp;
    if (!i_run || ((i_dir != dir_q) && (duty_q != 7'd0))) begin
      tgt = 7'd0;
    end
  end

  // Next-state and ramp datapath; brake overrides every state.
  always_comb begin
    state_next = state;
    duty_next  = duty_q;
    ramp_next  = ramp_cnt;
    dir_next   = dir_q;
    dead_next  = dead_q;

    case (state)
      IDLE: begin
        duty_next = 7'd0;
        ramp_next = '0;
        dead_next = 1'b0;
        if (i_run && (tgt != 7'd0)) begin
          dir_next   = i_dir;
          state_next = RAMP;
        end
      end

      RAMP: begin
        if (tick) begin
          ramp_next = ramp_wrap ? '0 : ramp_cnt + RAMP_W'(1);
        end
        if (ramp_wrap) begin
          dead_next = 1'b0;
          if (duty_q < tgt) begin
            duty_next = duty_q + 7'd1;
          end else if (duty_q > tgt) begin
            duty_next = duty_q - 7'd1;
          end
        end

        if ((duty_q != 7'd0) && (duty_q == tgt)) begin
          state_next = RUN;
          ramp_next  = '0;
        end else if (duty_q == 7'd0) begin
          if (!i_run) begin
            state_next = IDLE;
          end else if (i_dir != dir_q) begin
            // Zero crossing reached: flip direction and restart the step interval as a dead time.
            dir_next  = i_dir;
            dead_next = 1'b1;
            duty_next = 7'd0;
            ramp_next = '0;
          end else if (tgt == 7'd0) begin
            state_next = IDLE;
          end
        end
      end

      RUN: begin
        ramp_next = '0;
        if (tgt != duty_q) begin
          state_next = RAMP;
        end
      end

      BRAKE: begin
        duty_next = 7'd0;
        ramp_next = '0;
        dead_next = 1'b0;
        if (!i_brake) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (i_brake) begin
      state_next = BRAKE;
      duty_next  = 7'd0;
      ramp_next  = '0;
      dead_next  = 1'b0;
      dir_next   = dir_q;
    end
  end

  // State and ramp datapath registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= IDLE;
      duty_q   <= 7'd0;
      ramp_cnt <= '0;
      dir_q    <= 1'b0;
      dead_q   <= 1'b0;
    end else begin
      state    <= state_next;
      duty_q   <= duty_next;
      ramp_cnt <= ramp_next;
      dir_q    <= dir_next;
      dead_q   <= dead_next;
    end
  end

  assign drive = (state == RAMP) || (state == RUN);

  // Registered pin drive: PWM only while driving, bridge per latched direction, short-brake high-high.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      o_pwm <= 1'b0;
      o_in1 <= 1'b0;
      o_in2 <= 1'b0;
    end else begin
      o_pwm <= drive && (7'(pwm_cnt) < duty_shadow);
      o_in1 <= (state == BRAKE) || (drive && !dead_q && !dir_q);
      o_in2 <= (state == BRAKE) || (drive && !dead_q && dir_q);
    end
  end

  assign o_duty_now = duty_q;
  assign o_busy     = (state == RAMP);
  assign o_state    = state;

endmodule

// File: doc/motor_pwm_ramp.md
# motor_pwm_ramp

Soft-start PWM motor driver that consumes the 100 kHz square wave from the system prescaler and produces the H-bridge drive for the drum motor. It derives a 1 kHz PWM at 1 % resolution. It ramps the applied duty toward the requested target one step at a time, enforces a zero-duty crossing before any direction reversal, and overrides everything with an immediate short-brake. It sits between the control/memory registers (target duty, run, direction, brake) and the motor H-bridge pins.

## Interface
- `PERIOD_TICKS`, 100: PWM period in 100 kHz ticks; also the full-scale duty value.
- `RAMP_DIV`, 10: ticks between successive 1-step duty changes.
- `sysclk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `i_100khz_clk` in 1: prescaler output, used as data only and never as a clock.
- `i_duty_target` in 7: requested duty, 0..100 %; values above `PERIOD_TICKS` are clamped to `PERIOD_TICKS`.
- `i_run` in 1: run request.
- `i_dir` in 1: 0 = forward, 1 = reverse.
- `i_brake` in 1: brake request; highest priority.
- `o_pwm` out 1: PWM output, registered.
- `o_in1` out 1: H-bridge input 1, registered.
- `o_in2` out 1: H-bridge input 2, registered.
- `o_duty_now` out 7: duty currently applied.
- `o_busy` out 1: high while in RAMP.
- `o_state` out 2: IDLE = 0, RAMP = 1, RUN = 2, BRAKE = 3.

## Operation
- **Tick generation**
  - `i_100khz_clk` is registered once; `tick` = current & ~previous.
  - `tick` is exactly one `sysclk` cycle wide, once per 100 kHz period.
- **PWM counter**
  - `pwm_cnt` runs 0..`PERIOD_TICKS`-1, advances on `tick`, and wraps to 0.
  - `duty_shadow` loads `o_duty_now` only when `pwm_cnt` wraps to 0, so there are no mid-period glitches.
  - `o_pwm` = (`pwm_cnt` < `duty_shadow`) in RAMP/RUN, and 0 otherwise.
  - Duty 0 gives a constant low; duty 100 gives a constant high.
- **Effective target `tgt`**
  - `tgt` = 0 when `i_run` = 0, or when `i_dir` ≠ latched `dir_q` while `o_duty_now` > 0.
  - Otherwise `tgt` = clamp(`i_duty_target`).
- **IDLE**
  - Outputs: `o_duty_now` = 0, `o_in1` = `o_in2` = 0.
  - If `i_run` and `tgt` > 0: latch `dir_q` = `i_dir`, clear `ramp_cnt`, go to RAMP.
- **RAMP**
  - `ramp_cnt` counts `tick`s 0..`RAMP_DIV`-1.
  - On wrap, `o_duty_now` moves ±1 toward `tgt`.
  - When `o_duty_now` == `tgt` > 0: go to RUN.
  - When `o_duty_now` == 0 and `i_run` = 0: go to IDLE.
  - When `o_duty_now` == 0, `i_run` = 1 and `i_dir` ≠ `dir_q`: latch the new `dir_q`, drive `o_in1` = `o_in2` = 0 for that step interval, and stay in RAMP.
- **RUN**
  - Holds `o_duty_now`.
  - Any `tgt` ≠ `o_duty_now`: clear `ramp_cnt` and go to RAMP. This covers a target change, a run drop, or a direction change.
- **Bridge drive in RAMP/RUN**
  - `dir_q` = 0: `o_in1` = 1, `o_in2` = 0.
  - `dir_q` = 1: `o_in1` = 0, `o_in2` = 1.
- **BRAKE**
  - Entered from any state the cycle after `i_brake` = 1 is sampled.
  - Outputs: `o_pwm` = 0, `o_in1` = `o_in2` = 1, `o_duty_now` = 0; `duty_shadow`, `ramp_cnt` and `pwm_cnt` cleared.
  - Stays while `i_brake` = 1; goes to IDLE the cycle after release.
  - `i_brake` wins over a simultaneous `i_run`, `i_dir` or target change.
- **Reset**
  - State IDLE; every output is 0; all counters and `duty_shadow` are 0.
  - Reset mid-ramp drops the drive immediately with no ramp-down.

## Timing
- With 12 MHz `sysclk`, `tick` occurs every 120 cycles.
- `o_pwm`/`o_in*` change 1 `sysclk` after the `tick` (or the state change) that causes them.
- One duty step takes `RAMP_DIV` ticks (100 µs). A full 0→100 ramp takes 1000 ticks (10 ms).
- A new duty reaches `o_pwm` at the next `pwm_cnt` wrap, at most `PERIOD_TICKS` ticks later.
- Brake latency: `o_in1` = `o_in2` = 1 and `o_pwm` = 0 within 2 `sysclk` cycles of `i_brake` asserting, independent of `tick`.
- Sizing: counter widths come from `$clog2` of their terminal counts. Duty compare is unsigned, 7 bits.

## Test plan
- **Reset:** assert `reset` for 3 cycles mid-RUN → next cycle all outputs 0 and `o_state` = 0; `pwm_cnt` restarts from 0.
- **Soft start:** `i_run` = 1, `i_dir` = 0, target 50 → `o_in1` = 1, `o_in2` = 0; `o_duty_now` +1 every 10 ticks; RUN after 500 ticks; measured `o_pwm` high for 50 of 100 ticks per period.
- **Clamp and extremes:**
  - target 120 → ramps to 100, and `o_pwm` stays constantly high once the shadow loads.
  - target 0 with run → stays IDLE.
- **Reversal:** in RUN at 30, flip `i_dir` → ramps down to 0 (300 ticks), one step interval with both bridge inputs 0, then `o_in1` = 0, `o_in2` = 1 and ramps back up to 30.
- **Brake:**
  - `i_brake` pulse mid-ramp at duty 17 → within 2 cycles `o_pwm` = 0, `o_in1` = `o_in2` = 1, duty 0.
  - On release → IDLE; then, with run still asserted, restart from 0.
  - Brake asserted in the same cycle as `i_run` rises → BRAKE wins.
- **Glitch-free update:** change target in RUN when `pwm_cnt` = 40 → `o_pwm` width in the current period is unchanged; the new width applies from the next wrap.
